multibank_read_return: RTL and testbench

Downstream companion of the bank address demultiplexer in the 4-bank memory. It records the bank select of every issued read and delays it to match the bank read latency. When that latency has elapsed, it picks the returning bank's read data and queues it in a small response FIFO. The FIFO has a valid/ready handshake toward the consumer. A credit counter throttles read issue so the FIFO can never overflow. The banks themselves cannot stall.

---
 rtl/multibank_pkg.sv | 15 +
 rtl/multibank_resp_fifo.sv | 68 ++++++
 rtl/multibank_read_return.sv | 104 ++++++++++
 tb/tb_multibank_read_return.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multibank_pkg.sv
// Shared types for the 4-bank read-return path: bank select and the
// in-flight read tag that travels down the latency pipeline.
package multibank_pkg;

  localparam int NUM_BANKS      = 4;
  localparam int BANK_SEL_WIDTH = 2;

  typedef logic [BANK_SEL_WIDTH-1:0] bank_sel_t;

  typedef struct packed {
    logic      valid;
    bank_sel_t sel;
  } tag_t;

endpackage

// File: rtl/multibank_resp_fifo.sv
// Show-ahead response FIFO: the head entry is visible on o_rdata whenever
// the FIFO is non-empty and reads as zero when empty.
module multibank_resp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  input  logic                       i_pop,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign o_full  = (count_q == CNT_MAX);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q];

  // Guards keep pointers coherent even if a caller misbehaves.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/multibank_read_return.sv
// Delays each issued read's bank select by the bank latency, captures the
// returning bank word into the response FIFO, and throttles issue by credits.
module multibank_read_return
  import multibank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int DEPTH      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rd_en,
  input  logic [1:0]              i_sel,
  output logic                    o_rd_ready,
  input  logic [DATA_WIDTH-1:0]   i_bank_rdata0,
  input  logic [DATA_WIDTH-1:0]   i_bank_rdata1,
  input  logic [DATA_WIDTH-1:0]   i_bank_rdata2,
  input  logic [DATA_WIDTH-1:0]   i_bank_rdata3,
  output logic                    o_rvalid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  input  logic                    i_rready,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CRD_ONE = 1;
  localparam logic [CW-1:0] CRD_MAX = CW'(DEPTH);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("multibank_read_return: RD_LATENCY must be 1..4");
  end
  if (ADDR_WIDTH < BANK_SEL_WIDTH) begin : g_bad_addr
    $error("multibank_read_return: ADDR_WIDTH too small for bank select");
  end

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  tag_t                  tag_q [RD_LATENCY];
  tag_t                  tag_d [RD_LATENCY];
  tag_t                  tag_last;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  accept, pop, push;
  logic                  fifo_full, fifo_empty;

  assign bank_rdata[0] = i_bank_rdata0;
  assign bank_rdata[1] = i_bank_rdata1;
  assign bank_rdata[2] = i_bank_rdata2;
  assign bank_rdata[3] = i_bank_rdata3;

  // Ready comes only from the credit register so it never depends on i_rready.
  assign o_rd_ready = (credits_q < CRD_MAX);
  assign accept     = i_rd_en && o_rd_ready;
  assign o_rvalid   = !fifo_empty;
  assign pop        = o_rvalid && i_rready;

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_d[gi] = accept ? tag_t'{valid: 1'b1, sel: bank_sel_t'(i_sel)} : tag_t'('0);
    end else begin : g_shift
      assign tag_d[gi] = tag_q[gi-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign tag_last = tag_q[RD_LATENCY-1];
  assign push     = tag_last.valid;

  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CRD_ONE;
      2'b01:   credits_d = credits_q - CRD_ONE;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) credits_q <= '0;
    else       credits_q <= credits_d;
  end

  multibank_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (bank_rdata[tag_last.sel]),
    .i_pop   (pop),
    .o_rdata (o_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );

endmodule

// File: tb/tb_multibank_read_return.sv
// Directed bench for the read-return path at RD_LATENCY 1 and 3, with a
// short random scoreboard phase on the latency-1 instance.
module tb_multibank_read_return;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rd_en, rd_ready, rvalid, rready;
  logic [1:0]    sel;
  logic [DW-1:0] b0, b1, b2, b3, rdata;
  logic [2:0]    count;

  logic          rd_en3, rd_ready3, rvalid3, rready3;
  logic [1:0]    sel3;
  logic [DW-1:0] c0, c1, c2, c3, rdata3;
  logic [2:0]    count3;

  int n_checks = 0;
  int n_pass   = 0;

  multibank_read_return #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_sel(sel), .o_rd_ready(rd_ready),
    .i_bank_rdata0(b0), .i_bank_rdata1(b1), .i_bank_rdata2(b2), .i_bank_rdata3(b3),
    .o_rvalid(rvalid), .o_rdata(rdata), .i_rready(rready), .o_count(count));

  multibank_read_return #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .DEPTH(DEPTH)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en3), .i_sel(sel3), .o_rd_ready(rd_ready3),
    .i_bank_rdata0(c0), .i_bank_rdata1(c1), .i_bank_rdata2(c2), .i_bank_rdata3(c3),
    .o_rvalid(rvalid3), .o_rdata(rdata3), .i_rready(rready3), .o_count(count3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0] exp_b2b [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
  logic [2:0] exp_bp_cnt [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

  // Scoreboard state for the random phase.
  logic [7:0] sb_q [$];
  logic       m_pend_v;
  logic [1:0] m_pend_sel;
  int         m_credits;
  logic       m_acc, m_pop, m_ready;
  logic [7:0] m_bdat;

  initial begin
    rst = 1'b1;
    rd_en = 0; sel = 0; rready = 0; b0 = 0; b1 = 0; b2 = 0; b3 = 0;
    rd_en3 = 0; sel3 = 0; rready3 = 0; c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    tick(); tick();
    rst = 1'b0;

    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rd_ready", rd_ready, 1);
    check("rst_count", count, 0);
    check("rst3_rvalid", rvalid3, 0);
    check("rst3_rd_ready", rd_ready3, 1);

    // Single read of bank 2; bank data valid at the edge after accept.
    rd_en = 1; sel = 2; rready = 1;
    tick();
    rd_en = 0; b2 = 8'hA5;
    check("t1_rvalid_early", rvalid, 0);
    tick();
    b2 = 8'hFF;
    check("t1_rvalid", rvalid, 1);
    check("t1_rdata", rdata, 8'hA5);
    check("t1_rd_ready", rd_ready, 1);
    check("t1_count", count, 1);
    tick();
    check("t1_rvalid_after", rvalid, 0);
    check("t1_rdata_after", rdata, 0);
    check("t1_count_after", count, 0);

    // Back-to-back reads to banks 0..3.
    b0 = 8'h11; b1 = 8'h22; b2 = 8'h33; b3 = 8'h44;
    for (int k = 0; k < 6; k++) begin
      rd_en = (k < 4);
      sel   = 2'(k);
      tick();
      check($sformatf("b2b_rvalid_%0d", k), rvalid, (exp_b2b[k] != 0));
      check($sformatf("b2b_rdata_%0d", k), rdata, exp_b2b[k]);
      check($sformatf("b2b_rd_ready_%0d", k), rd_ready, 1);
    end
    rd_en = 0;

    // Backpressure: only 4 accepts, ready drops after the 4th.
    rready = 0; rd_en = 1;
    for (int k = 0; k < 6; k++) begin
      sel = 2'(k);
      tick();
      check($sformatf("bp_rd_ready_%0d", k), rd_ready, (k < 3));
      check($sformatf("bp_count_%0d", k), count, exp_bp_cnt[k]);
    end
    rd_en = 0;
    check("bp_head", rdata, 8'h11);
    rready = 1;
    tick();
    rready = 0;
    check("bp_pop_count", count, 3);
    check("bp_pop_rdata", rdata, 8'h22);
    check("bp_pop_rd_ready", rd_ready, 1);
    rready = 1;
    tick(); check("bp_drain_33", rdata, 8'h33);
    tick(); check("bp_drain_44", rdata, 8'h44);
    tick(); check("bp_drain_empty", rvalid, 0);
    rready = 0;

    // Simultaneous accept and pop with 3 credits in use.
    rd_en = 1;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      tick();
    end
    check("sim_pre_count", count, 2);
    sel = 3; rready = 1;
    tick();
    rd_en = 0; rready = 0;
    check("sim_count", count, 2);
    check("sim_rdata", rdata, 8'h22);
    check("sim_rd_ready", rd_ready, 1);
    tick();
    check("sim_count_push", count, 3);
    check("sim_rd_ready_hold", rd_ready, 1);
    rready = 1;
    tick(); check("sim_drain_33", rdata, 8'h33);
    tick(); check("sim_drain_44", rdata, 8'h44);
    tick(); check("sim_drain_empty", count, 0);
    tick();

    // Random phase against the scoreboard, starting idle and empty.
    m_pend_v = 0; m_pend_sel = 0; m_credits = 0;
    for (int k = 0; k < 20; k++) begin
      rd_en  = ($urandom_range(0, 3) != 0);
      sel    = 2'($urandom_range(0, 3));
      rready = 1'($urandom_range(0, 1));
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      m_ready = (m_credits < DEPTH);
      check($sformatf("rnd_rd_ready_%0d", k), rd_ready, m_ready);
      check($sformatf("rnd_rvalid_%0d", k), rvalid, (sb_q.size() > 0));
      check($sformatf("rnd_rdata_%0d", k), rdata, (sb_q.size() > 0) ? sb_q[0] : 8'h00);
      check($sformatf("rnd_count_%0d", k), count, sb_q.size());
      m_acc = rd_en && m_ready;
      m_pop = (sb_q.size() > 0) && rready;
      case (m_pend_sel)
        2'd0: m_bdat = b0;
        2'd1: m_bdat = b1;
        2'd2: m_bdat = b2;
        default: m_bdat = b3;
      endcase
      tick();
      if (m_pop) void'(sb_q.pop_front());
      if (m_pend_v) sb_q.push_back(m_bdat);
      m_pend_v   = m_acc;
      m_pend_sel = sel;
      m_credits  = m_credits + int'(m_acc) - int'(m_pop);
    end
    rd_en = 0; rready = 1;
    repeat (6) tick();
    check("rnd_end_count", count, 0);
    check("rnd_end_rd_ready", rd_ready, 1);
    rready = 0;

    // Latency-3 instance: only the bank value at T+3 is captured.
    rd_en3 = 1; sel3 = 1; c1 = 8'h00;
    tick();
    rd_en3 = 0; c1 = 8'h11;
    check("l3_rvalid_t0", rvalid3, 0);
    tick();
    c1 = 8'h22;
    check("l3_rvalid_t1", rvalid3, 0);
    tick();
    c1 = 8'h5C;
    check("l3_rvalid_t2", rvalid3, 0);
    tick();
    c1 = 8'h77;
    check("l3_rvalid_t3", rvalid3, 1);
    check("l3_rdata_t3", rdata3, 8'h5C);
    check("l3_count_t3", count3, 1);
    tick();
    check("l3_rdata_hold", rdata3, 8'h5C);
    rready3 = 1;
    tick();
    rready3 = 0;
    check("l3_rvalid_popped", rvalid3, 0);

    // Async reset with one queued and two reads in flight.
    c0 = 8'hAB; c2 = 8'hCD; c3 = 8'hEF; b0 = 8'h99;
    rd_en3 = 1; sel3 = 0;
    tick();
    rd_en3 = 0;
    tick();
    rd_en3 = 1; sel3 = 2; rd_en = 1; sel = 0; rready = 0;
    tick();
    sel3 = 3; rd_en = 0;
    tick();
    rd_en3 = 0;
    check("ar_pre_count3", count3, 1);
    check("ar_pre_rdata3", rdata3, 8'hAB);
    check("ar_pre_count", count, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_rvalid3", rvalid3, 0);
    check("ar_count3", count3, 0);
    check("ar_rdata3", rdata3, 0);
    check("ar_rd_ready3", rd_ready3, 1);
    check("ar_rvalid", rvalid, 0);
    check("ar_count", count, 0);
    #2 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ar_post_rvalid3_%0d", k), rvalid3, 0);
      check($sformatf("ar_post_rvalid_%0d", k), rvalid, 0);
    end
    check("ar_post_rd_ready3", rd_ready3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
